debounce_events: RTL and testbench
==================================

# debounce_events

Parametrised multi-channel debouncer and button-event generator for the board's slide switches and push-buttons. Each channel is synchronised, normalised to active-high, and debounced. It also produces single-cycle press, release, long-press and auto-repeat pulses. It sits between the raw board inputs and the game FSM/timer logic, so downstream blocks consume clean one-cycle events instead of levels.

## Interface
- NUM_CHANNELS, 22: number of independent input channels (≥1).
- DELAY_COUNTS, 2500: consecutive stable cycles needed to accept a new level (≥1).
- LONG_PRESS_COUNTS, 25_000_000: cycles of continuous debounced-high before long_press fires (≥1).
- REPEAT_COUNTS, 5_000_000: auto-repeat period in cycles after long_press (≥1).
- ACTIVE_LOW_MASK, 0 (NUM_CHANNELS bits): bit i = 1 inverts channel i before synchronisation (for KEY inputs).

Ports:
- clk  input  1  system clock; one clock domain.
- reset_n  input  1  asynchronous, active-low reset.
- button  input  NUM_CHANNELS  raw, asynchronous inputs.
- repeat_en  input  NUM_CHANNELS  per-channel auto-repeat enable; synchronous, sampled every cycle.
- level  output  NUM_CHANNELS  debounced active-high level.
- press  output  NUM_CHANNELS  one-cycle pulse when level rises.
- release  output  NUM_CHANNELS  one-cycle pulse when level falls.
- long_press  output  NUM_CHANNELS  one-cycle pulse when the hold time reaches LONG_PRESS_COUNTS.
- repeat  output  NUM_CHANNELS  one-cycle pulse every REPEAT_COUNTS cycles after long_press, when enabled.

## Operation
- Normalise each channel: norm[i] = button[i] XOR ACTIVE_LOW_MASK[i]. Pass it through a 2-flop synchroniser to give sync[i].
- Debounce counter per channel, width $clog2(DELAY_COUNTS+1):
  - sync == level: counter clears to 0.
  - sync != level and counter == DELAY_COUNTS-1: level toggles and counter clears.
  - Otherwise: counter increments.
  - Any return to the old value before the threshold clears the counter. No level change occurs.
- Per-channel state machine:
  - IDLE: level = 0.
  - PRESSED: level = 1, long_press not yet issued.
  - HELD: long_press issued.
- Transitions:
  - IDLE→PRESSED on a level rise. press = 1 and the hold counter clears.
  - PRESSED: the hold counter increments each cycle. At hold == LONG_PRESS_COUNTS-1: long_press = 1, go to HELD, hold counter clears.
  - HELD: the hold counter counts 0..REPEAT_COUNTS-1 and wraps. On the wrap edge, repeat = repeat_en[i].
  - With repeat_en low, the counter still wraps but repeat stays 0. Re-enabling resumes on the next wrap.
  - PRESSED/HELD→IDLE on a level fall. release = 1 and the hold counter clears.
- Priority: a level fall wins over long_press or repeat on the same edge. Only release fires.
- Hold counter width: $clog2(max(LONG_PRESS_COUNTS, REPEAT_COUNTS)+1). The hold counter never overflows.
- Channels are fully independent. Simultaneous events on several channels all fire in the same cycle.

## Timing
- All outputs are registered. Reset values: level, press, release, long_press and repeat are all 0. Synchroniser flops, counters and state (IDLE) are also 0.
- Reset is asynchronous on assertion and mid-operation. In-progress debounce/hold counts are discarded and no pulse is emitted.
- Masked channels read 0 in reset, so a released active-low KEY produces no event after reset.
- A channel held active through reset produces press on edge DELAY_COUNTS+1 after reset_n deasserts.
- Latency: let edge 0 be the first clk edge sampling the new raw value. level updates and press/release pulse on edge DELAY_COUNTS+1, visible for exactly one cycle.
- With E as the press edge:
  - long_press occurs on edge E+LONG_PRESS_COUNTS.
  - repeat occurs on edges E+LONG_PRESS_COUNTS+k·REPEAT_COUNTS, k≥1.
- Pulse outputs never stay high for two consecutive cycles on one channel when DELAY_COUNTS, LONG_PRESS_COUNTS and REPEAT_COUNTS are ≥2.

## Test plan
Configuration for all scenarios: NUM_CHANNELS=4, DELAY_COUNTS=4, LONG_PRESS_COUNTS=10, REPEAT_COUNTS=3, ACTIVE_LOW_MASK=4'b0011.
- Glitch rejection: button[2] high for 3 cycles, then low -> level[2] stays 0; press/release stay 0.
- Active-low press: button[0] 1→0 and held -> level[0] rises on edge 5; press[0] high for one cycle; no other channel changes.
- Long press with repeat: repeat_en[0]=1, hold 20 cycles past press edge E -> long_press[0] at E+10; repeat[0] at E+13, E+16, E+19; release[0] 5 edges after the raw release.
- Repeat disabled: same stimulus with repeat_en[0]=0 -> long_press[0] at E+10 only; no repeat pulses.
- Reset mid-operation: in HELD state, pulse reset_n low for 2 cycles with button held -> all outputs 0 immediately; press reissued 5 edges after deassertion; no release pulse.
- Simultaneous: all four channels change to active on the same cycle -> press = 4'b1111 in one cycle; release on all four in the same cycle when released together.

Source files
------------

// File: rtl/debounce_events.sv
// Multi-channel switch/button debouncer producing press, release, long-press and auto-repeat pulses.
// Latency: DELAY_COUNTS+1 edges from raw change to level/press/release; no backpressure, all outputs registered.
module debounce_events #(
   parameter int                      NUM_CHANNELS      = 22,
   parameter int                      DELAY_COUNTS      = 2500,
   parameter int                      LONG_PRESS_COUNTS = 25_000_000,
   parameter int                      REPEAT_COUNTS     = 5_000_000,
   parameter logic [NUM_CHANNELS-1:0] ACTIVE_LOW_MASK   = '0
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic [NUM_CHANNELS-1:0] i_button,
   input  logic [NUM_CHANNELS-1:0] i_repeat_en,
   output logic [NUM_CHANNELS-1:0] o_level,
   output logic [NUM_CHANNELS-1:0] o_press,
   output logic [NUM_CHANNELS-1:0] o_release,
   output logic [NUM_CHANNELS-1:0] o_long_press,
   output logic [NUM_CHANNELS-1:0] o_repeat
);

   localparam int DW   = $clog2(DELAY_COUNTS + 1);
   localparam int HMAX = (LONG_PRESS_COUNTS > REPEAT_COUNTS) ? LONG_PRESS_COUNTS : REPEAT_COUNTS;
   localparam int HW   = $clog2(HMAX + 1);

   localparam logic [DW-1:0] DLAST = DW'(DELAY_COUNTS - 1);
   localparam logic [HW-1:0] LLAST = HW'(LONG_PRESS_COUNTS - 1);
   localparam logic [HW-1:0] RLAST = HW'(REPEAT_COUNTS - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_HELD    = 2'd2
   } state_t;

   logic [NUM_CHANNELS-1:0] w_norm;
   logic [NUM_CHANNELS-1:0] r_sync1;
   logic [NUM_CHANNELS-1:0] r_sync2;

   // Inverting before the synchroniser makes released KEYs read 0 straight out of reset.
   assign w_norm = i_button ^ ACTIVE_LOW_MASK;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_norm;
         r_sync2 <= r_sync1;
      end
   end

   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
      logic [DW-1:0] r_dcnt;
      logic          r_level;
      logic          w_toggle;
      logic          w_rise;
      logic          w_fall;
      state_t        r_state;
      state_t        w_state_nxt;
      logic [HW-1:0] r_hold;
      logic [HW-1:0] w_hold_nxt;
      logic          w_press;
      logic          w_release;
      logic          w_long;
      logic          w_rep;
      logic          r_press;
      logic          r_release;
      logic          r_long;
      logic          r_rep;

      assign w_toggle = (r_sync2[i] != r_level) && (r_dcnt == DLAST);
      assign w_rise   = w_toggle && !r_level;
      assign w_fall   = w_toggle && r_level;

      always_ff @(posedge i_clk or negedge i_reset_n) begin
         if (!i_reset_n) begin
            r_dcnt  <= '0;
            r_level <= 1'b0;
         end else if (r_sync2[i] == r_level) begin
            r_dcnt  <= '0;
         end else if (w_toggle) begin
            r_dcnt  <= '0;
            r_level <= ~r_level;
         end else begin
            r_dcnt  <= r_dcnt + DW'(1);
         end
      end

      // State register; event pulses are registered alongside it.
      always_ff @(posedge i_clk or negedge i_reset_n) begin
         if (!i_reset_n) begin
            r_state   <= ST_IDLE;
            r_hold    <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_rep     <= 1'b0;
         end else begin
            r_state   <= w_state_nxt;
            r_hold    <= w_hold_nxt;
            r_press   <= w_press;
            r_release <= w_release;
            r_long    <= w_long;
            r_rep     <= w_rep;
         end
      end

      always_comb begin
         w_state_nxt = r_state;
         w_hold_nxt  = r_hold;
         case (r_state)
            ST_IDLE: begin
               if (w_rise) begin
                  w_state_nxt = ST_PRESSED;
                  w_hold_nxt  = '0;
               end
            end
            ST_PRESSED: begin
               if (w_fall) begin
                  w_state_nxt = ST_IDLE;
                  w_hold_nxt  = '0;
               end else if (r_hold == LLAST) begin
                  w_state_nxt = ST_HELD;
                  w_hold_nxt  = '0;
               end else begin
                  w_hold_nxt  = r_hold + HW'(1);
               end
            end
            ST_HELD: begin
               if (w_fall) begin
                  w_state_nxt = ST_IDLE;
                  w_hold_nxt  = '0;
               end else if (r_hold == RLAST) begin
                  w_hold_nxt  = '0;
               end else begin
                  w_hold_nxt  = r_hold + HW'(1);
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_hold_nxt  = '0;
            end
         endcase
      end

      // A falling level suppresses long_press/repeat on the same edge.
      always_comb begin
         w_press   = (r_state == ST_IDLE) && w_rise;
         w_release = (r_state != ST_IDLE) && w_fall;
         w_long    = (r_state == ST_PRESSED) && !w_fall && (r_hold == LLAST);
         w_rep     = (r_state == ST_HELD) && !w_fall && (r_hold == RLAST) && i_repeat_en[i];
      end

      assign o_level[i]      = r_level;
      assign o_press[i]      = r_press;
      assign o_release[i]    = r_release;
      assign o_long_press[i] = r_long;
      assign o_repeat[i]     = r_rep;
   end

endmodule

// File: tb/tb_debounce_events.sv
// Scoreboard bench for debounce_events: expected pulses are queued with their edge number
// as stimulus is driven, and compared against the outputs sampled 1ns after every clock edge.
module tb_debounce_events;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [N-1:0] button;
   logic [N-1:0] repeat_en;
   logic [N-1:0] level, press, rel, lp, rep;

   debounce_events #(
      .NUM_CHANNELS      (4),
      .DELAY_COUNTS      (4),
      .LONG_PRESS_COUNTS (10),
      .REPEAT_COUNTS     (3),
      .ACTIVE_LOW_MASK   (4'b0011)
   ) u_dut (
      .i_clk        (clk),
      .i_reset_n    (reset_n),
      .i_button     (button),
      .i_repeat_en  (repeat_en),
      .o_level      (level),
      .o_press      (press),
      .o_release    (rel),
      .o_long_press (lp),
      .o_repeat     (rep)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           edge_n;
      logic [N-1:0] press;
      logic [N-1:0] rel;
      logic [N-1:0] lp;
      logic [N-1:0] rep;
      logic [N-1:0] lvl;
   } ev_t;

   ev_t          exp_q[$];
   int           edge_cnt = 0;
   int           checks   = 0;
   int           errors   = 0;
   logic [N-1:0] exp_lvl  = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_cnt, obs, exp);
      end
   endtask

   task automatic push(input int e, input logic [N-1:0] p, input logic [N-1:0] r,
                       input logic [N-1:0] l, input logic [N-1:0] q, input logic [N-1:0] lv);
      ev_t ev;
      ev.edge_n = e; ev.press = p; ev.rel = r; ev.lp = l; ev.rep = q; ev.lvl = lv;
      exp_q.push_back(ev);
   endtask

   task automatic wait_edge(input int target);
      while (edge_cnt < target) @(negedge clk);
   endtask

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   always @(posedge clk) begin : mon
      ev_t ev;
      #1;
      if (exp_q.size() != 0 && exp_q[0].edge_n == edge_cnt) begin
         ev = exp_q.pop_front();
         chk("press",      32'(press), 32'(ev.press));
         chk("release",    32'(rel),   32'(ev.rel));
         chk("long_press", 32'(lp),    32'(ev.lp));
         chk("repeat",     32'(rep),   32'(ev.rep));
         chk("level_evt",  32'(level), 32'(ev.lvl));
      end else begin
         chk("idle_pulses", 32'({press, rel, lp, rep}), 32'h0);
      end
   end

   initial begin : stim
      int e;
      reset_n   = 1'b0;
      button    = 4'b0011;
      repeat_en = 4'b0000;
      @(negedge clk);
      chk("rst_level",   32'(level), 32'h0);
      chk("rst_press",   32'(press), 32'h0);
      chk("rst_release", 32'(rel),   32'h0);
      chk("rst_long",    32'(lp),    32'h0);
      chk("rst_repeat",  32'(rep),   32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("post_rst_level", 32'(level), 32'h0);

      // Glitch shorter than the debounce window on channel 2
      button[2] = 1'b1;
      repeat (3) @(negedge clk);
      button[2] = 1'b0;
      repeat (10) @(negedge clk);
      chk("glitch_level", 32'(level), 32'h0);

      // All channels become active together, then release together
      button  = 4'b1100;
      e       = edge_cnt + 6;
      exp_lvl = 4'b1111;
      push(e, 4'b1111, 4'b0000, 4'b0000, 4'b0000, exp_lvl);
      wait_edge(e + 2);
      chk("simul_level", 32'(level), 32'hf);
      button  = 4'b0011;
      exp_lvl = 4'b0000;
      push(e + 8, 4'b0000, 4'b1111, 4'b0000, 4'b0000, exp_lvl);
      wait_edge(e + 20);

      // Active-low channel 0: long press with auto-repeat
      repeat_en  = 4'b0001;
      button[0]  = 1'b0;
      e          = edge_cnt + 6;
      exp_lvl[0] = 1'b1;
      push(e,      4'b0001, 4'b0000, 4'b0000, 4'b0000, exp_lvl);
      push(e + 10, 4'b0000, 4'b0000, 4'b0001, 4'b0000, exp_lvl);
      for (int k = 13; k <= 19; k += 3) push(e + k, 4'b0000, 4'b0000, 4'b0000, 4'b0001, exp_lvl);
      wait_edge(e + 20);
      chk("hold_level", 32'(level), 32'h1);
      button[0] = 1'b1;
      push(e + 22, 4'b0000, 4'b0000, 4'b0000, 4'b0001, exp_lvl);
      push(e + 25, 4'b0000, 4'b0000, 4'b0000, 4'b0001, exp_lvl);
      exp_lvl[0] = 1'b0;
      push(e + 26, 4'b0000, 4'b0001, 4'b0000, 4'b0000, exp_lvl);
      wait_edge(e + 36);

      // Same hold with repeat disabled on channel 0 only
      repeat_en  = 4'b1110;
      button[0]  = 1'b0;
      e          = edge_cnt + 6;
      exp_lvl[0] = 1'b1;
      push(e,      4'b0001, 4'b0000, 4'b0000, 4'b0000, exp_lvl);
      push(e + 10, 4'b0000, 4'b0000, 4'b0001, 4'b0000, exp_lvl);
      wait_edge(e + 20);
      button[0]  = 1'b1;
      exp_lvl[0] = 1'b0;
      push(e + 26, 4'b0000, 4'b0001, 4'b0000, 4'b0000, exp_lvl);
      wait_edge(e + 36);

      // Reset while channel 1 is in HELD, button kept active throughout
      repeat_en  = 4'b0010;
      button[1]  = 1'b0;
      e          = edge_cnt + 6;
      exp_lvl[1] = 1'b1;
      push(e,      4'b0010, 4'b0000, 4'b0000, 4'b0000, exp_lvl);
      push(e + 10, 4'b0000, 4'b0000, 4'b0010, 4'b0000, exp_lvl);
      push(e + 13, 4'b0000, 4'b0000, 4'b0000, 4'b0010, exp_lvl);
      wait_edge(e + 14);
      reset_n = 1'b0;
      exp_lvl = 4'b0000;
      #1;
      chk("mid_rst_level",   32'(level), 32'h0);
      chk("mid_rst_press",   32'(press), 32'h0);
      chk("mid_rst_release", 32'(rel),   32'h0);
      chk("mid_rst_long",    32'(lp),    32'h0);
      chk("mid_rst_repeat",  32'(rep),   32'h0);
      repeat (2) @(negedge clk);
      reset_n    = 1'b1;
      e          = edge_cnt + 6;
      exp_lvl[1] = 1'b1;
      push(e, 4'b0010, 4'b0000, 4'b0000, 4'b0000, exp_lvl);
      wait_edge(e + 2);
      button[1]  = 1'b1;
      exp_lvl[1] = 1'b0;
      push(e + 8, 4'b0000, 4'b0010, 4'b0000, 4'b0000, exp_lvl);

      for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'h0);
      repeat (5) @(negedge clk);
      chk("final_level", 32'(level), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
